// File: rtl/ct_biu_csr_access_ctrl.sv
// BIU CSR access sequencer: turns one arbitrated CSR request into a registered L2 req/ack access.
// Optional macro CT_BIU_CSR_TIMEOUT_EN forces completion after TIMEOUT_CYC REQ cycles without ack.
module ct_biu_csr_access_ctrl #(
  parameter int TIMEOUT_CYC = 255,
  parameter int ADDR_W      = 12
) (
  input  logic                forever_cpuclk,
  input  logic                cpurst,
  input  logic                biu_csr_sel,
  input  logic [15:0]         biu_csr_op,
  input  logic [63:0]         biu_csr_wdata,
  output logic                biu_csr_cmplt,
  output logic [127:0]        biu_csr_rdata,
  output logic                biu_l2_csr_req,
  output logic                biu_l2_csr_wr,
  output logic [ADDR_W-1:0]   biu_l2_csr_addr,
  output logic [63:0]         biu_l2_csr_wdata,
  input  logic                l2_biu_csr_ack,
  input  logic [127:0]        l2_biu_csr_rdata,
  output logic                biu_csr_busy,
  output logic                biu_csr_timeout
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] REQ   = 2'd1;
  localparam logic [1:0] CMPLT = 2'd2;
  localparam logic [1:0] DROP  = 2'd3;

  logic [1:0] state;
  logic [1:0] cmd;
  logic       rd_capture;
  logic       timeout_hit;
  logic       timeout_q;
  logic       unused_op_bits;

  assign cmd            = biu_csr_op[15:14];
  assign unused_op_bits = ^biu_csr_op[13:12];

`ifdef CT_BIU_CSR_TIMEOUT_EN
  logic [7:0] to_cnt;

  // Counter is zero whenever REQ is entered because it is held clear outside REQ.
  always_ff @(posedge forever_cpuclk) begin
    if (cpurst) begin
      to_cnt <= 8'd0;
    end else if (state != REQ) begin
      to_cnt <= 8'd0;
    end else if (!l2_biu_csr_ack) begin
      to_cnt <= to_cnt + 8'd1;
    end
  end

  assign timeout_hit = (to_cnt == 8'(TIMEOUT_CYC - 1));
`else
  logic [7:0] unused_timeout_cfg;

  assign unused_timeout_cfg = 8'(TIMEOUT_CYC);
  assign timeout_hit        = 1'b0;
`endif

  always_ff @(posedge forever_cpuclk) begin
    if (cpurst) begin
      state            <= IDLE;
      biu_l2_csr_req   <= 1'b0;
      biu_l2_csr_wr    <= 1'b0;
      biu_l2_csr_addr  <= '0;
      biu_l2_csr_wdata <= 64'h0;
      biu_csr_rdata    <= 128'h0;
      biu_csr_cmplt    <= 1'b0;
      timeout_q        <= 1'b0;
      rd_capture       <= 1'b0;
    end else begin
      biu_csr_cmplt <= 1'b0;
      timeout_q     <= 1'b0;
      case (state)
        IDLE: begin
          if (biu_csr_sel) begin
            if (cmd != 2'b00) begin
              biu_l2_csr_addr  <= biu_csr_op[ADDR_W-1:0];
              biu_l2_csr_wr    <= cmd[1];
              biu_l2_csr_wdata <= biu_csr_wdata;
              rd_capture       <= cmd[0];
              biu_l2_csr_req   <= 1'b1;
              state            <= REQ;
            end else begin
              // Invalid command completes locally without touching L2.
              biu_csr_rdata <= 128'h0;
              biu_csr_cmplt <= 1'b1;
              state         <= CMPLT;
            end
          end
        end
        REQ: begin
          if (l2_biu_csr_ack) begin
            biu_csr_rdata  <= rd_capture ? l2_biu_csr_rdata : 128'h0;
            biu_l2_csr_req <= 1'b0;
            biu_csr_cmplt  <= 1'b1;
            state          <= CMPLT;
          end else if (timeout_hit) begin
            biu_csr_rdata  <= 128'h0;
            biu_l2_csr_req <= 1'b0;
            biu_csr_cmplt  <= 1'b1;
            timeout_q      <= 1'b1;
            state          <= CMPLT;
          end
        end
        CMPLT: begin
          state <= DROP;
        end
        default: begin
          // Requester must release sel before another access is accepted.
          if (!biu_csr_sel) begin
            state <= IDLE;
          end
        end
      endcase
    end
  end

  assign biu_csr_busy    = (state != IDLE);
  assign biu_csr_timeout = timeout_q;

endmodule

// File: tb/tb_ct_biu_csr_access_ctrl.sv
// Self-checking bench for ct_biu_csr_access_ctrl; define CT_BIU_CSR_TIMEOUT_EN to exercise the timeout build.
module tb_ct_biu_csr_access_ctrl;

`ifdef CT_BIU_CSR_TIMEOUT_EN
  localparam int TOC = 4;
`else
  localparam int TOC = 255;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         sel;
  logic [15:0]  op;
  logic [63:0]  wdata;
  logic         cmplt;
  logic [127:0] csr_rdata;
  logic         req;
  logic         l2_wr;
  logic [11:0]  l2_addr;
  logic [63:0]  l2_wdata;
  logic         ack;
  logic [127:0] l2_rdata;
  logic         busy;
  logic         timeout;

  int total = 0;
  int bad   = 0;

  logic [127:0] exp_rdata;

  int           obs_req_cycles;
  int           obs_cmplt_cycle;
  int           obs_cmplt_count;
  logic [11:0]  obs_addr;
  logic         obs_wr;
  logic [63:0]  obs_wdata;
  logic [127:0] obs_rdata;
  logic         obs_timeout;
  logic         obs_busy_end;

  ct_biu_csr_access_ctrl #(.TIMEOUT_CYC(TOC), .ADDR_W(12)) dut (
    .forever_cpuclk   (clk),
    .cpurst           (rst),
    .biu_csr_sel      (sel),
    .biu_csr_op       (op),
    .biu_csr_wdata    (wdata),
    .biu_csr_cmplt    (cmplt),
    .biu_csr_rdata    (csr_rdata),
    .biu_l2_csr_req   (req),
    .biu_l2_csr_wr    (l2_wr),
    .biu_l2_csr_addr  (l2_addr),
    .biu_l2_csr_wdata (l2_wdata),
    .l2_biu_csr_ack   (ack),
    .l2_biu_csr_rdata (l2_rdata),
    .biu_csr_busy     (busy),
    .biu_csr_timeout  (timeout)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: what the requester should see back for a given command.
  function automatic logic [127:0] model_rdata(input logic [1:0] cmd, input logic [127:0] l2rd);
    if (cmd == 2'b01 || cmd == 2'b11) return l2rd;
    return 128'h0;
  endfunction

  // Drives one access with the L2 acking ack_after cycles into REQ (-1 = never); records observations only.
  task automatic drive_access(input logic [1:0] cmd, input logic [11:0] addr, input logic [63:0] wd,
                              input int ack_after, input logic [127:0] l2rd);
    obs_req_cycles  = 0;
    obs_cmplt_cycle = -1;
    obs_cmplt_count = 0;
    obs_addr = '0; obs_wr = 1'b0; obs_wdata = '0; obs_rdata = '0; obs_timeout = 1'b0;
    sel = 1'b1; op = {cmd, 2'b00, addr}; wdata = wd; ack = 1'b0;
    for (int cyc = 1; cyc <= 400 && obs_cmplt_cycle < 0; cyc++) begin
      tick();
      if (req) begin
        if (obs_req_cycles == 0) begin
          obs_addr = l2_addr; obs_wr = l2_wr; obs_wdata = l2_wdata;
        end
        obs_req_cycles++;
      end
      if (cmplt) begin
        obs_cmplt_cycle = cyc; obs_cmplt_count++; obs_rdata = csr_rdata; obs_timeout = timeout;
      end
      ack = req && (obs_req_cycles - 1 == ack_after);
      l2_rdata = ack ? l2rd : {$urandom, $urandom, $urandom, $urandom};
    end
    sel = 1'b0; ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (cmplt) obs_cmplt_count++;
      if (req) obs_req_cycles++;
    end
    obs_busy_end = busy;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    total++; if ({req, l2_wr, cmplt, busy, timeout} !== 5'b0) begin bad++; $display("[TB] FAIL reset_ctrl: got %b want 00000", {req, l2_wr, cmplt, busy, timeout}); end
    total++; if (l2_addr !== 12'h0 || l2_wdata !== 64'h0) begin bad++; $display("[TB] FAIL reset_payload: got %h/%h want 0/0", l2_addr, l2_wdata); end
    total++; if (csr_rdata !== 128'h0) begin bad++; $display("[TB] FAIL reset_rdata: got %h want 0", csr_rdata); end
    rst = 1'b0;
    exp_rdata = 128'h0;
  endtask

  task automatic test_read();
    logic [127:0] l2rd;
    l2rd = {16{8'hA5}};
    drive_access(2'b01, 12'h123, 64'h1111_2222_3333_4444, 3, l2rd);
    exp_rdata = model_rdata(2'b01, l2rd);
    total++; if (obs_addr !== 12'h123 || obs_wr !== 1'b0) begin bad++; $display("[TB] FAIL read_addr_wr: got %h/%b want 123/0", obs_addr, obs_wr); end
    total++; if (obs_req_cycles !== 4) begin bad++; $display("[TB] FAIL read_req_cycles: got %0d want 4", obs_req_cycles); end
    total++; if (obs_cmplt_cycle !== 5 || obs_cmplt_count !== 1) begin bad++; $display("[TB] FAIL read_cmplt: got cycle %0d count %0d want 5/1", obs_cmplt_cycle, obs_cmplt_count); end
    total++; if (obs_rdata !== exp_rdata || csr_rdata !== exp_rdata) begin bad++; $display("[TB] FAIL read_rdata: got %h want %h", obs_rdata, exp_rdata); end
    total++; if (obs_busy_end !== 1'b0) begin bad++; $display("[TB] FAIL read_rearm: got busy %b want 0", obs_busy_end); end
  endtask

  task automatic test_write();
    drive_access(2'b10, 12'h010, 64'hDEAD_BEEF, 0, {$urandom, $urandom, $urandom, $urandom});
    exp_rdata = 128'h0;
    total++; if (obs_wr !== 1'b1 || obs_wdata !== 64'hDEAD_BEEF || obs_addr !== 12'h010) begin bad++; $display("[TB] FAIL write_payload: got %b/%h/%h want 1/deadbeef/010", obs_wr, obs_wdata, obs_addr); end
    total++; if (obs_cmplt_cycle !== 2 || obs_cmplt_count !== 1) begin bad++; $display("[TB] FAIL write_cmplt: got cycle %0d count %0d want 2/1", obs_cmplt_cycle, obs_cmplt_count); end
    total++; if (obs_rdata !== 128'h0) begin bad++; $display("[TB] FAIL write_rdata: got %h want 0", obs_rdata); end
  endtask

  task automatic test_invalid_hold();
    int extra_cmplt;
    int extra_req;
    logic [127:0] l2rd;
    sel = 1'b1; op = 16'h0010; ack = 1'b0;
    tick();
    exp_rdata = 128'h0;
    total++; if (cmplt !== 1'b1 || req !== 1'b0 || csr_rdata !== exp_rdata) begin bad++; $display("[TB] FAIL invalid_cmplt: got cmplt %b req %b rdata %h want 1/0/0", cmplt, req, csr_rdata); end
    extra_cmplt = 0; extra_req = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (cmplt) extra_cmplt++;
      if (req) extra_req++;
    end
    total++; if (extra_cmplt !== 0 || extra_req !== 0) begin bad++; $display("[TB] FAIL invalid_held_sel: got cmplt %0d req %0d want 0/0", extra_cmplt, extra_req); end
    sel = 1'b0;
    tick();
    l2rd = {$urandom, $urandom, $urandom, $urandom};
    sel = 1'b1; op = 16'h4042;
    tick();
    total++; if (req !== 1'b1 || l2_addr !== 12'h042) begin bad++; $display("[TB] FAIL invalid_rearm: got req %b addr %h want 1/042", req, l2_addr); end
    ack = 1'b1; l2_rdata = l2rd;
    tick();
    ack = 1'b0; sel = 1'b0;
    exp_rdata = l2rd;
    total++; if (cmplt !== 1'b1 || csr_rdata !== exp_rdata) begin bad++; $display("[TB] FAIL invalid_rearm_cmplt: got %b/%h want 1/%h", cmplt, csr_rdata, exp_rdata); end
    tick(); tick();
  endtask

  task automatic test_spurious_ack();
    logic [127:0] l2rd;
    ack = 1'b1; l2_rdata = 128'h1;
    tick();
    ack = 1'b0;
    total++; if (cmplt !== 1'b0 || req !== 1'b0 || csr_rdata !== exp_rdata) begin bad++; $display("[TB] FAIL ack_in_idle: got cmplt %b rdata %h want 0/%h", cmplt, csr_rdata, exp_rdata); end
    l2rd = {$urandom | 32'h1, $urandom, $urandom, $urandom};
    sel = 1'b1; op = 16'hC055;
    tick();
    ack = 1'b1; l2_rdata = l2rd;
    tick();
    exp_rdata = l2rd;
    ack = 1'b0;
    tick();
    ack = 1'b1; l2_rdata = 128'h1;
    tick();
    ack = 1'b0;
    total++; if (cmplt !== 1'b0 || csr_rdata !== exp_rdata || busy !== 1'b1) begin bad++; $display("[TB] FAIL ack_in_drop: got cmplt %b busy %b rdata %h want 0/1/%h", cmplt, busy, csr_rdata, exp_rdata); end
    sel = 1'b0;
    tick();
    total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL drop_release: got busy %b want 0", busy); end
  endtask

  task automatic test_reset_mid();
    logic [127:0] l2rd;
    sel = 1'b1; op = 16'h4077;
    tick(); tick();
    total++; if (req !== 1'b1) begin bad++; $display("[TB] FAIL rstmid_req_before: got %b want 1", req); end
    rst = 1'b1; sel = 1'b0;
    tick();
    exp_rdata = 128'h0;
    total++; if (req !== 1'b0 || busy !== 1'b0 || cmplt !== 1'b0 || csr_rdata !== exp_rdata) begin bad++; $display("[TB] FAIL rstmid_state: got req %b busy %b cmplt %b want 0/0/0", req, busy, cmplt); end
    rst = 1'b0;
    tick();
    total++; if (cmplt !== 1'b0) begin bad++; $display("[TB] FAIL rstmid_no_cmplt: got %b want 0", cmplt); end
    l2rd = {$urandom, $urandom, $urandom, $urandom};
    drive_access(2'b01, 12'h3AB, 64'h0, 1, l2rd);
    exp_rdata = model_rdata(2'b01, l2rd);
    total++; if (obs_cmplt_cycle !== 3 || obs_cmplt_count !== 1 || obs_rdata !== exp_rdata) begin bad++; $display("[TB] FAIL rstmid_follow: got cycle %0d count %0d rdata %h want 3/1/%h", obs_cmplt_cycle, obs_cmplt_count, obs_rdata, exp_rdata); end
  endtask

`ifdef CT_BIU_CSR_TIMEOUT_EN
  task automatic test_timeout();
    logic [127:0] l2rd;
    drive_access(2'b01, 12'h0FE, 64'h0, -1, 128'h0);
    exp_rdata = 128'h0;
    total++; if (obs_req_cycles !== TOC || obs_cmplt_cycle !== TOC + 1) begin bad++; $display("[TB] FAIL timeout_timing: got req %0d cmplt %0d want %0d/%0d", obs_req_cycles, obs_cmplt_cycle, TOC, TOC + 1); end
    total++; if (obs_timeout !== 1'b1 || obs_rdata !== 128'h0) begin bad++; $display("[TB] FAIL timeout_flag: got %b rdata %h want 1/0", obs_timeout, obs_rdata); end
    l2rd = {$urandom, $urandom, $urandom, $urandom};
    drive_access(2'b11, 12'h0FD, 64'h5, TOC - 1, l2rd);
    exp_rdata = model_rdata(2'b11, l2rd);
    total++; if (obs_timeout !== 1'b0 || obs_rdata !== exp_rdata || obs_cmplt_cycle !== TOC + 1) begin bad++; $display("[TB] FAIL timeout_ack_wins: got to %b cycle %0d rdata %h want 0/%0d/%h", obs_timeout, obs_cmplt_cycle, obs_rdata, TOC + 1, exp_rdata); end
  endtask
`else
  task automatic test_timeout();
    int bad_cycles;
    logic [127:0] l2rd;
    bad_cycles = 0;
    sel = 1'b1; op = 16'h40FE; ack = 1'b0;
    for (int i = 0; i < 305; i++) begin
      tick();
      if (req !== 1'b1 || timeout !== 1'b0 || cmplt !== 1'b0) bad_cycles++;
    end
    total++; if (bad_cycles !== 0) begin bad++; $display("[TB] FAIL no_timeout_wait: got %0d bad cycles want 0", bad_cycles); end
    l2rd = {$urandom, $urandom, $urandom, $urandom};
    ack = 1'b1; l2_rdata = l2rd;
    tick();
    ack = 1'b0; sel = 1'b0;
    exp_rdata = l2rd;
    total++; if (cmplt !== 1'b1 || timeout !== 1'b0 || csr_rdata !== exp_rdata) begin bad++; $display("[TB] FAIL no_timeout_late_ack: got cmplt %b to %b want 1/0", cmplt, timeout); end
    tick(); tick();
  endtask
`endif

  task automatic test_random();
    logic [1:0]   cmd;
    logic [11:0]  addr;
    logic [63:0]  wd;
    logic [127:0] l2rd;
    int           ack_after;
    int           exp_cyc;
    int           exp_reqs;
    for (int n = 0; n < 20; n++) begin
      cmd       = 2'($urandom_range(0, 3));
      addr      = 12'($urandom);
      wd        = {$urandom, $urandom};
      l2rd      = {$urandom, $urandom, $urandom, $urandom};
      ack_after = $urandom_range(0, (TOC < 6) ? TOC - 1 : 5);
      drive_access(cmd, addr, wd, ack_after, l2rd);
      exp_rdata = model_rdata(cmd, l2rd);
      exp_cyc   = (cmd == 2'b00) ? 1 : ack_after + 2;
      exp_reqs  = (cmd == 2'b00) ? 0 : ack_after + 1;
      total++; if (obs_cmplt_cycle !== exp_cyc || obs_cmplt_count !== 1 || obs_req_cycles !== exp_reqs) begin bad++; $display("[TB] FAIL rand_timing[%0d]: got cyc %0d cnt %0d req %0d want %0d/1/%0d", n, obs_cmplt_cycle, obs_cmplt_count, obs_req_cycles, exp_cyc, exp_reqs); end
      total++; if (obs_rdata !== exp_rdata || csr_rdata !== exp_rdata) begin bad++; $display("[TB] FAIL rand_rdata[%0d]: got %h want %h", n, obs_rdata, exp_rdata); end
      if (cmd != 2'b00) begin
        total++; if (obs_addr !== addr || obs_wr !== cmd[1] || obs_wdata !== wd) begin bad++; $display("[TB] FAIL rand_payload[%0d]: got %h/%b/%h want %h/%b/%h", n, obs_addr, obs_wr, obs_wdata, addr, cmd[1], wd); end
      end
      total++; if (obs_busy_end !== 1'b0 || obs_timeout !== 1'b0) begin bad++; $display("[TB] FAIL rand_rearm[%0d]: got busy %b to %b want 0/0", n, obs_busy_end, obs_timeout); end
    end
  endtask

  initial begin
    rst = 1'b1; sel = 1'b0; op = 16'h0; wdata = 64'h0; ack = 1'b0; l2_rdata = 128'h0;
    exp_rdata = 128'h0;
    test_reset();
    test_read();
    test_invalid_hold();
    test_write();
    test_spurious_ack();
    test_reset_mid();
    test_timeout();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
